// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: op and state encodings shared by the sequencer and its shift core
package shift_sequencer_pkg;
    typedef enum logic [2:0] {
        OP_CLR,
        OP_LOAD,
        OP_LSR,
        OP_LSL,
        OP_ASR,
        OP_SIN,
        OP_ROR,
        OP_ROL
    } op_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: command/status bundle between a front end (master) and the sequencer (slave)
//   master drives start/op/cnt/din/sin/abort, reads ready/busy/done/q
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    modport master (output start, op, cnt, din, sin, abort, input ready, busy, done, q);
    modport slave (input start, op, cnt, din, sin, abort, output ready, busy, done, q);
endinterface

// File: rtl/shift_sequencer_core.sv
// shift_core: WIDTH-bit multi-mode register, applies one op step per enabled clock
//   clk/rst: clock, async active-high reset; en: step enable; op: step kind
//   din: parallel load value; sin: serial bit into MSB; q: register contents
module shift_core
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  op_t              op,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] nxt;
    always_comb begin
        nxt = q;
        case (op)
            OP_CLR:  nxt = '0;
            OP_LOAD: nxt = din;
            OP_LSR:  nxt = {1'b0, q[WIDTH-1:1]};
            OP_LSL:  nxt = {q[WIDTH-2:0], 1'b0};
            OP_ASR:  nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_SIN:  nxt = {sin, q[WIDTH-1:1]};
            OP_ROR:  nxt = {q[0], q[WIDTH-1:1]};
            OP_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            default: nxt = q;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else if (en) q <= nxt;
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts {op, cnt, din} commands and steps the shift core cnt times, pulsing done at the end
//   clk/rst: clock, async active-high reset; bus: slave side of shift_sequencer_if
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst,
    shift_sequencer_if.slave bus
);
    state_t           state, nxt;
    op_t              op_r;
    logic [WIDTH-1:0] din_r;
    logic [CNT_W-1:0] ctr;
    logic [WIDTH-1:0] q;
    logic             accept, step, last;
    assign accept = state == S_IDLE && bus.start;
    // abort suppresses the step on the edge it is seen
    assign step   = state == S_RUN && !bus.abort;
    // clear/load are single-step regardless of the counter
    assign last   = op_r == OP_CLR || op_r == OP_LOAD || ctr == CNT_W'(1);
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (bus.start) nxt = (bus.op[2:1] == 2'b00 || bus.cnt != '0) ? S_RUN : S_DONE;
            S_RUN:   nxt = bus.abort ? S_IDLE : (last ? S_DONE : S_RUN);
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_r  <= OP_CLR;
            din_r <= '0;
            ctr   <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                op_r  <= op_t'(bus.op);
                din_r <= bus.din;
                ctr   <= bus.cnt;
            end else if (step) begin
                ctr <= ctr - 1'b1;
            end
        end
    end
    shift_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .en  (step),
        .op  (op_r),
        .din (din_r),
        .sin (bus.sin),
        .q   (q)
    );
    assign bus.q     = q;
    assign bus.ready = state == S_IDLE;
    assign bus.busy  = state == S_RUN;
    assign bus.done  = state == S_DONE;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed spec scenarios plus randomized traffic against a command-level model
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    shift_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] m_q = 8'h00;
    logic [7:0] m_din = 8'h00;
    logic [2:0] m_op = 3'd0;
    int         m_left = 0;
    bit         m_done = 1'b0;

    function automatic logic [7:0] mstep(input logic [2:0] op, input logic [7:0] q,
                                         input logic [7:0] din, input logic sin);
        logic [7:0] r;
        case (op)
            3'd0: r = 8'h00;
            3'd1: r = din;
            3'd2: r = q >> 1;
            3'd3: r = q << 1;
            3'd4: r = 8'($signed(q) >>> 1);
            3'd5: r = (q >> 1) | (8'(sin) << 7);
            3'd6: r = (q >> 1) | (q << 7);
            default: r = (q << 1) | (q >> 7);
        endcase
        return r;
    endfunction

    // Command-level model: a command owns the register for a number of
    // steps, then reports completion for one cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = 8'h00;
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (bus.abort) begin
                m_left = 0;
            end else begin
                m_q = mstep(m_op, m_q, m_din, bus.sin);
                m_left--;
                m_done = (m_left == 0);
            end
        end else if (bus.start) begin
            m_op = bus.op;
            m_din = bus.din;
            m_left = (bus.op < 3'd2) ? 1 : int'(bus.cnt);
            m_done = (m_left == 0);
        end
    end

    always @(posedge clk) if (bus.done) done_cnt++;

    always @(negedge clk) begin
        logic [10:0] act, exp;
        act = {bus.ready, bus.busy, bus.done, bus.q};
        exp = {!m_done && m_left == 0, m_left > 0, m_done, m_q};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model t=%0t rdy/busy/done/q act=%0h exp=%0h", $time, act, exp);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] din);
        int n = 0;
        while (!bus.ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.ready) chk("ready_timeout", 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.op = op;
        bus.cnt = cnt;
        bus.din = din;
        tick();
        bus.start = 1'b0;
    endtask

    // lat counts edges from the accept edge to the edge that samples done
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int lat;
        int d0;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.cnt = 4'd0;
        bus.din = 8'h00;
        bus.sin = 1'b0;
        bus.abort = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
        chk("reset_q", 32'(bus.q), 32'h00);

        issue(3'd1, 4'd0, 8'hA5);
        wait_done(lat);
        chk("load_lat", lat, 2);
        chk("load_q", 32'(bus.q), 32'hA5);

        issue(3'd7, 4'd3, 8'h00);
        tick();
        chk("rol_step1", 32'(bus.q), 32'h4B);
        tick();
        chk("rol_step2", 32'(bus.q), 32'h96);
        tick();
        chk("rol_step3", 32'(bus.q), 32'h2D);
        chk("rol_done_4th", 32'(bus.done), 32'd1);

        issue(3'd1, 4'd0, 8'h80);
        wait_done(lat);
        issue(3'd4, 4'd2, 8'h00);
        wait_done(lat);
        chk("asr_lat", lat, 3);
        chk("asr_q", 32'(bus.q), 32'hE0);
        issue(3'd0, 4'd9, 8'hFF);
        wait_done(lat);
        chk("clr_lat", lat, 2);
        chk("clr_q", 32'(bus.q), 32'h00);

        bus.sin = 1'b1;
        issue(3'd5, 4'd4, 8'h00);
        wait_done(lat);
        chk("sin_q", 32'(bus.q), 32'hF0);
        bus.sin = 1'b0;
        issue(3'd2, 4'd0, 8'h00);
        wait_done(lat);
        chk("cnt0_lat", lat, 1);
        chk("cnt0_q", 32'(bus.q), 32'hF0);

        issue(3'd1, 4'd0, 8'h01);
        wait_done(lat);
        issue(3'd3, 4'd5, 8'h00);
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.op = 3'd1;
        bus.din = 8'hFF;
        tick();
        chk("lsl_step1", 32'(bus.q), 32'h02);
        bus.start = 1'b0;
        tick();
        chk("lsl_step2", 32'(bus.q), 32'h04);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_q", 32'(bus.q), 32'h04);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_q_hold", 32'(bus.q), 32'h04);

        issue(3'd6, 4'd7, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_state", {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
        d0 = done_cnt;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_no_done", done_cnt, d0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 400) == 0;
            bus.start = ($urandom % 3) == 0;
            bus.op = 3'($urandom);
            bus.cnt = ($urandom % 8 == 0) ? 4'd15 : 4'($urandom_range(0, 6));
            bus.din = 8'($urandom);
            bus.sin = 1'($urandom);
            bus.abort = ($urandom % 12) == 0;
            tick();
        end
        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (20) tick();
        chk("final_idle", 32'(bus.ready), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
